joypad_ctrl: RTL and testbench
==============================

Name: joypad_ctrl

Overview:
- Owns all eight Game Boy keys: synchronizes them, debounces them with one shared lockout timebase, and exposes the DMG P1/JOYP register (0xFF00) to the CPU bus.
- Produces the joypad interrupt request for the interrupt controller.
- A single prescaler is time-shared by eight per-key lockout FSMs, so eight full-width delay counters are not needed.

Parameters:
- TICK_CYCLES, 20000: clock cycles per shared lockout tick; must be ≥2.
- LOCK_TICKS, 10: ticks a key stays locked after each accepted edge; must be ≥1.
- TICK_W, derived (ceil log2 TICK_CYCLES): prescaler width.
- LOCK_W, derived (ceil log2(LOCK_TICKS+1)): per-key lock counter width.

Ports:
- clock, input, 1: posedge clock.
- reset, input, 1: reset, asynchronous, active-high.
- btn_raw, input, 8: raw keys, active-high; bit 0 Right, 1 Left, 2 Up, 3 Down, 4 A, 5 B, 6 Select, 7 Start.
- cs, input, 1: CPU access to 0xFF00 this cycle.
- we, input, 1: write strobe, qualified by cs.
- din, input, 8: write data.
- dout, output, 8: P1 read value, combinational from registered state.
- btn_state, output, 8: debounced key levels.
- press_pulse, output, 8: one-cycle pulse per accepted press.
- int_req, output, 1: one-cycle joypad interrupt request.

Behaviour:
- **Reset:** sync flops = 0, prescaler = 0, all FSMs IDLE, lock counters = 0, sel[1:0] = 2'b11, btn_state = 0, press_pulse = 0, int_req = 0, prev_nib = 4'hF, so dout = 8'hFF. Reset mid-lockout abandons the lockout immediately.
- **Synchronizer:** 2-flop per bit. btn_raw first sampled high at edge N gives s = 1 after edge N+1.
- **Prescaler:** counts 0..TICK_CYCLES-1 and wraps. tick = 1 for the single cycle where count == TICK_CYCLES-1. It is free-running and shared, never restarted by key activity.
- **Per-key FSM (states IDLE, PRESS, DOWN, RELEASE):**
  - IDLE (level 0): s = 1 → PRESS, lock = 0, press_pulse[i] = 1 for that one registered cycle.
  - PRESS (level 1): s ignored. On tick: if lock == LOCK_TICKS-1 → DOWN, else lock+1.
  - DOWN (level 1): s = 0 → RELEASE, lock = 0.
  - RELEASE (level 0): s ignored. On tick: if lock == LOCK_TICKS-1 → IDLE, else lock+1.
  - Lockout length therefore lies in ((LOCK_TICKS-1)·TICK_CYCLES, LOCK_TICKS·TICK_CYCLES] cycles.
  - btn_state[i] = 1 in PRESS or DOWN and is registered with the state.
  - Press latency: raw high at edge N → btn_state[i] and press_pulse[i] high after edge N+2.
- **Keys are independent:** simultaneous presses on several keys each pulse in the same cycle and all use the same tick.
- **Register write:** cs & we at an edge latches sel <= din[5:4]; other din bits are ignored. Writes take effect on dout the next cycle.
- **Register read:**
  - dir = btn_state[3:0], act = btn_state[7:4].
  - nib = ~( (sel[0]==0 ? dir : 0) | (sel[1]==0 ? act : 0) ).
  - dout = {2'b11, sel, nib}. dout is valid regardless of cs.
- **Interrupt:** prev_nib <= nib every cycle. int_req <= |(prev_nib & ~nib), so it pulses on any nib bit falling 1→0 and is registered one cycle after the fall.
  - Falls caused by a sel write that newly exposes a held key also raise int_req.
  - Rises never raise int_req.
  - Several simultaneous falls produce one pulse.

Test Plan (TICK_CYCLES=4, LOCK_TICKS=2):
1. **Reset and idle read:** assert reset mid-operation → dout=8'hFF, btn_state=0, all pulses 0 at once, asynchronously.
2. **Press latency and pulse:** btn_raw=8'h10 sampled at edge N → btn_state=8'h10 and press_pulse=8'h10 after edge N+2; press_pulse=0 after edge N+3. sel=2'b01 → dout=8'hDE, and int_req=1 the cycle after nib falls.
3. **Bounce rejection:** toggle btn_raw[0] every cycle for 5 cycles after an accepted press → exactly one press_pulse, btn_state[0] stays 1 through PRESS. Release glitches within the lockout do not produce a second pulse.
4. **Release lockout:** hold Down, release, then re-press within 4 cycles of entering RELEASE → no pulse until the FSM returns to IDLE (within ≤8 cycles); then press_pulse[3]=1.
5. **Select multiplexing:** hold Start and Right; write din=8'h20 → dout=8'hEE (Right only); write 8'h10 → dout=8'hD7 (Start only); write 8'h00 → 8'hC6; write 8'h30 → 8'hFF. Each write that exposes a key pulses int_req once.
6. **Simultaneous keys:** press A and B on the same edge → press_pulse=8'h30 in one cycle; sel=2'b01 → single int_req pulse, dout low nibble=4'hC.

Source files
------------

// File: rtl/joypad_ctrl.sv
// Game Boy joypad: 2-flop key synchronizers, per-key debounce lockout driven by
// one shared tick prescaler, the P1/JOYP register and the joypad interrupt pulse.

module joypad_key #(
  parameter int LOCK_TICKS = 10,
  parameter int LOCK_W     = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic s,
  input  logic tick,
  output logic level,
  output logic pulse
);
  typedef enum logic [1:0] {IDLE, PRESS, DOWN, RELEASE} key_state_e;

  key_state_e        state_q, state_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic              pulse_q, pulse_d;
  logic              lock_done;

  assign lock_done = (lock_q == LOCK_W'(LOCK_TICKS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lock_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      pulse_q <= pulse_d;
    end
  end

  // The key input is ignored while locked; only shared ticks advance the lock.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: if (s) begin
        state_d = PRESS;
        lock_d  = '0;
        pulse_d = 1'b1;
      end
      PRESS: if (tick) begin
        if (lock_done) state_d = DOWN;
        else           lock_d  = lock_q + LOCK_W'(1);
      end
      DOWN: if (!s) begin
        state_d = RELEASE;
        lock_d  = '0;
      end
      RELEASE: if (tick) begin
        if (lock_done) state_d = IDLE;
        else           lock_d  = lock_q + LOCK_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign level = (state_q == PRESS) || (state_q == DOWN);
  assign pulse = pulse_q;
endmodule

module joypad_ctrl #(
  parameter int TICK_CYCLES = 20000,
  parameter int LOCK_TICKS  = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] btn_raw,
  input  logic       cs,
  input  logic       we,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [7:0] btn_state,
  output logic [7:0] press_pulse,
  output logic       int_req
);
  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int LOCK_W = (LOCK_TICKS > 0) ? $clog2(LOCK_TICKS + 1) : 1;

  logic [7:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [3:0]        prev_nib_q, prev_nib_d;
  logic              int_q, int_d;
  logic              tick;
  logic [3:0]        nib;
  logic              unused_din;

  assign unused_din = ^{din[7:6], din[3:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cnt_q      <= '0;
      sel_q      <= 2'b11;
      prev_nib_q <= 4'hF;
      int_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      prev_nib_q <= prev_nib_d;
      int_q      <= int_d;
    end
  end

  // Free-running prescaler; never restarted by key activity so all keys share it.
  assign tick = (cnt_q == TICK_W'(TICK_CYCLES - 1));

  // A select bit of 0 exposes its key group; a pressed exposed key reads as 0.
  assign nib = ~(({4{~sel_q[0]}} & btn_state[3:0]) |
                 ({4{~sel_q[1]}} & btn_state[7:4]));

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    cnt_d      = tick ? '0 : cnt_q + TICK_W'(1);
    sel_d      = (cs && we) ? din[5:4] : sel_q;
    prev_nib_d = nib;
    int_d      = |(prev_nib_q & ~nib);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_key
      joypad_key #(
        .LOCK_TICKS(LOCK_TICKS),
        .LOCK_W    (LOCK_W)
      ) u_key (
        .clock(clock),
        .reset(reset),
        .s    (sync2_q[gi]),
        .tick (tick),
        .level(btn_state[gi]),
        .pulse(press_pulse[gi])
      );
    end
  endgenerate

  assign dout    = {2'b11, sel_q, nib};
  assign int_req = int_q;
endmodule

// File: tb/tb_joypad_ctrl.sv
// Bench for joypad_ctrl: directed scenarios plus randomized traffic, all checked
// against a timestamp-based lockout model of the joypad.

module tb_joypad_ctrl;
  localparam int TC = 4;
  localparam int LT = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] btn_raw = '0;
  logic       cs = 1'b0, we = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout, btn_state, press_pulse;
  logic       int_req;

  joypad_ctrl #(.TICK_CYCLES(TC), .LOCK_TICKS(LT)) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .cs(cs), .we(we), .din(din),
    .dout(dout), .btn_state(btn_state), .press_pulse(press_pulse), .int_req(int_req)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model: a key may change level only on an edge strictly after its unlock edge.
  // Ticks land on edges that are multiples of TC, so the unlock edge after an
  // accepted change at edge E is (E/TC + LT)*TC.
  int         m_edge;
  int         m_unlock[8];
  logic [7:0] m_lvl, m_pulse, m_h1, m_h2;
  logic [1:0] m_sel;
  logic [3:0] m_prev;
  logic       m_int;

  function automatic logic [3:0] m_nib();
    logic [3:0] exposed;
    exposed = 4'h0;
    if (!m_sel[0]) exposed = exposed | m_lvl[3:0];
    if (!m_sel[1]) exposed = exposed | m_lvl[7:4];
    return ~exposed;
  endfunction

  function automatic logic [7:0] m_dout();
    return {2'b11, m_sel, m_nib()};
  endfunction

  task automatic model_reset();
    m_edge = 0;
    for (int i = 0; i < 8; i++) m_unlock[i] = 0;
    m_lvl = '0; m_pulse = '0; m_h1 = '0; m_h2 = '0;
    m_sel = 2'b11; m_prev = 4'hF; m_int = 1'b0;
  endtask

  task automatic step(input logic [7:0] raw, input logic w, input logic [7:0] d);
    logic [3:0] n;
    logic [7:0] sv;
    btn_raw = raw; cs = w; we = w; din = d;
    @(posedge clock);
    m_edge++;
    n  = m_nib();
    sv = m_h2;
    m_int  = |(m_prev & ~n);
    m_prev = n;
    m_h2 = m_h1;
    m_h1 = raw;
    m_pulse = '0;
    for (int i = 0; i < 8; i++) begin
      if (m_edge > m_unlock[i] && sv[i] != m_lvl[i]) begin
        m_lvl[i] = sv[i];
        if (sv[i]) m_pulse[i] = 1'b1;
        m_unlock[i] = (m_edge / TC + LT) * TC;
      end
    end
    if (w) m_sel = d[5:4];
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_raw = '0; cs = 1'b0; we = 1'b0; din = '0;
    #1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 20; i++) step(8'hFF, (i == 5), 8'h00);
    reset = 1'b1;
    #1;
    tests++; if (dout !== 8'hFF) begin fails++; $display("FAIL reset_dout got %h exp ff", dout); end
    tests++; if (btn_state !== 8'h00) begin fails++; $display("FAIL reset_btn_state got %h exp 00", btn_state); end
    tests++; if (press_pulse !== 8'h00) begin fails++; $display("FAIL reset_press_pulse got %h exp 00", press_pulse); end
    tests++; if (int_req !== 1'b0) begin fails++; $display("FAIL reset_int_req got %b exp 0", int_req); end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_press_latency();
    do_reset();
    step(8'h10, 0, 0);
    step(8'h10, 0, 0);
    tests++; if (btn_state !== 8'h00) begin fails++; $display("FAIL latency_early got %h exp 00", btn_state); end
    step(8'h10, 0, 0);
    tests++; if (btn_state !== 8'h10 || press_pulse !== 8'h10) begin
      fails++; $display("FAIL latency_press got %h/%h exp 10/10", btn_state, press_pulse); end
    step(8'h10, 0, 0);
    tests++; if (press_pulse !== 8'h00) begin fails++; $display("FAIL latency_pulse_end got %h exp 00", press_pulse); end
    step(8'h10, 1, 8'h10);
    tests++; if (dout !== 8'hDE) begin fails++; $display("FAIL latency_dout got %h exp de", dout); end
    tests++; if (int_req !== 1'b0) begin fails++; $display("FAIL latency_int_early got %b exp 0", int_req); end
    step(8'h10, 0, 0);
    tests++; if (int_req !== 1'b1) begin fails++; $display("FAIL latency_int got %b exp 1", int_req); end
    step(8'h10, 0, 0);
    tests++; if (int_req !== 1'b0 || {dout, int_req} !== {m_dout(), m_int}) begin
      fails++; $display("FAIL latency_int_end got %h/%b exp %h/%b", dout, int_req, m_dout(), m_int); end
  endtask

  task automatic test_bounce();
    logic [0:33] pat;
    int pulses;
    pat = {6'b101010, 10'h3FF, 4'b0101, 14'h0};
    pulses = 0;
    do_reset();
    for (int i = 0; i < 34; i++) begin
      step({7'h0, pat[i]}, 0, 0);
      pulses += int'(press_pulse[0]);
      tests++; if ({btn_state, press_pulse} !== {m_lvl, m_pulse}) begin
        fails++; $display("FAIL bounce_model edge=%0d got %h/%h exp %h/%h", m_edge, btn_state, press_pulse, m_lvl, m_pulse); end
      if (i >= 2 && i <= 7) begin
        tests++; if (btn_state[0] !== 1'b1) begin fails++; $display("FAIL bounce_hold edge=%0d got 0 exp 1", m_edge); end
      end
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL bounce_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_release_lockout();
    int pulses, at;
    pulses = 0; at = -1;
    do_reset();
    for (int i = 0; i < 12; i++) step(8'h08, 0, 0);
    step(8'h00, 0, 0);
    for (int k = 1; k <= 15; k++) begin
      step(8'h08, 0, 0);
      if (press_pulse[3]) begin pulses++; if (at < 0) at = k; end
      tests++; if ({btn_state, press_pulse} !== {m_lvl, m_pulse}) begin
        fails++; $display("FAIL relock_model edge=%0d got %h/%h exp %h/%h", m_edge, btn_state, press_pulse, m_lvl, m_pulse); end
    end
    tests++; if (pulses != 1 || at < 8 || at > 11) begin
      fails++; $display("FAIL relock_pulse got count %0d at %0d exp count 1 at 8..11", pulses, at); end
  endtask

  task automatic test_select();
    logic [7:0] wr [4];
    logic [7:0] ex [4];
    int         ic [4];
    int         cnt;
    wr = '{8'h20, 8'h10, 8'h00, 8'h30};
    ex = '{8'hEE, 8'hD7, 8'hC6, 8'hFF};
    ic = '{1, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 12; i++) step(8'h81, 0, 0);
    for (int j = 0; j < 4; j++) begin
      step(8'h81, 1, wr[j]);
      tests++; if (dout !== ex[j]) begin fails++; $display("FAIL select_dout wr=%h got %h exp %h", wr[j], dout, ex[j]); end
      cnt = 0;
      for (int k = 0; k < 3; k++) begin step(8'h81, 0, 0); cnt += int'(int_req); end
      tests++; if (cnt != ic[j]) begin fails++; $display("FAIL select_int wr=%h got %0d exp %0d", wr[j], cnt, ic[j]); end
    end
  endtask

  task automatic test_simultaneous();
    int cnt;
    do_reset();
    step(8'h30, 0, 0);
    step(8'h30, 0, 0);
    step(8'h30, 0, 0);
    tests++; if (press_pulse !== 8'h30) begin fails++; $display("FAIL simul_pulse got %h exp 30", press_pulse); end
    step(8'h30, 1, 8'h10);
    tests++; if (dout[3:0] !== 4'hC) begin fails++; $display("FAIL simul_nib got %h exp c", dout[3:0]); end
    cnt = 0;
    for (int k = 0; k < 4; k++) begin step(8'h30, 0, 0); cnt += int'(int_req); end
    tests++; if (cnt != 1) begin fails++; $display("FAIL simul_int got %0d exp 1", cnt); end
  endtask

  task automatic test_random();
    logic [7:0] raw;
    logic       w;
    raw = '0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5, 0) == 0) raw[$urandom_range(7, 0)] ^= 1'b1;
      w = ($urandom_range(11, 0) == 0);
      step(raw, w, 8'($urandom));
      tests++;
      if ({dout, btn_state, press_pulse, int_req} !== {m_dout(), m_lvl, m_pulse, m_int}) begin
        fails++;
        if (fails < 20) $display("FAIL random edge=%0d got %h/%h/%h/%b exp %h/%h/%h/%b", m_edge,
          dout, btn_state, press_pulse, int_req, m_dout(), m_lvl, m_pulse, m_int);
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_press_latency();
    test_bounce();
    test_release_lockout();
    test_select();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
